// File: rtl/cache_pkg.sv
// Shared definitions for the I/D cache memory arbiter: FSM encoding, burst geometry
// and the fill-address helper.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_owner_e;

    localparam int BLOCK_WORDS = 8;
    localparam int MEM_LATENCY = 4;
    localparam int WORD_IDX_W  = $clog2(BLOCK_WORDS);

    // 16-bit words, so the byte address of word idx is {block, idx, 0}
    function automatic logic [15:0] word_addr(input logic [11:0] blk,
                                              input logic [WORD_IDX_W-1:0] idx);
        return {blk, idx, 1'b0};
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Request/grant/memory bus between the two caches, the arbiter and shared memory.
interface cache_mem_arbiter_if;

    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdata_valid;

    logic        i_grant;
    logic        d_grant;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_data_valid;
    logic        d_data_valid;
    logic        i_done;
    logic        d_done;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdata_valid,
        output mem_addr, mem_enable, mem_wr, mem_wdata, i_grant, d_grant,
               fill_data, fill_word, i_data_valid, d_data_valid, i_done, d_done
    );

    // Cache/memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdata_valid,
        input  mem_addr, mem_enable, mem_wr, mem_wdata, i_grant, d_grant,
               fill_data, fill_word, i_data_valid, d_data_valid, i_done, d_done
    );

endinterface

// File: rtl/arb_burst_counter.sv
// Issue and return word counters for one 8-word fill burst, with last-beat detect.
module arb_burst_counter
    import cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  issue_step,
    input  logic                  beat,
    output logic [WORD_IDX_W-1:0] issue_idx,
    output logic                  issue_active,
    output logic [WORD_IDX_W-1:0] ret_cnt,
    output logic                  last_beat
);

    localparam logic [WORD_IDX_W-1:0] IDX_ZERO = WORD_IDX_W'(0);
    localparam logic [WORD_IDX_W-1:0] IDX_ONE  = WORD_IDX_W'(1);
    localparam logic [WORD_IDX_W-1:0] IDX_LAST = WORD_IDX_W'(BLOCK_WORDS - 1);

    logic [WORD_IDX_W-1:0] issue_idx_r;
    logic                  issue_active_r;
    logic [WORD_IDX_W-1:0] ret_cnt_r;

    // The parent registers word 0 itself on state entry, so issuing resumes at word 1
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_idx_r    <= IDX_ZERO;
            issue_active_r <= 1'b0;
            ret_cnt_r      <= IDX_ZERO;
        end else if (start) begin
            issue_idx_r    <= IDX_ONE;
            issue_active_r <= 1'b1;
            ret_cnt_r      <= IDX_ZERO;
        end else begin
            if (issue_step) begin
                issue_idx_r    <= issue_idx_r + IDX_ONE;
                issue_active_r <= (issue_idx_r != IDX_LAST);
            end
            if (beat) begin
                ret_cnt_r <= (ret_cnt_r == IDX_LAST) ? IDX_ZERO : (ret_cnt_r + IDX_ONE);
            end
        end
    end

    assign issue_idx    = issue_idx_r;
    assign issue_active = issue_active_r;
    assign ret_cnt      = ret_cnt_r;
    assign last_beat    = beat && (ret_cnt_r == IDX_LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/write-throughs onto one memory port.
// Define ARB_FIXED_PRIO_EN for fixed D-over-I priority; default is round-robin.
module cache_mem_arbiter
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
);

    arb_state_e            state_r;
    grant_owner_e          last_gnt_r;
    logic [11:0]           blk_r;
    logic [15:0]           mem_addr_r;
    logic                  mem_enable_r;
    logic                  mem_wr_r;
    logic [15:0]           mem_wdata_r;
    logic                  i_grant_r;
    logic                  d_grant_r;

    logic                  pick_i_s;
    logic                  pick_d_s;
    logic                  fill_s;
    logic                  beat_s;
    logic                  start_s;
    logic                  issue_step_s;
    logic [WORD_IDX_W-1:0] issue_idx_s;
    logic                  issue_active_s;
    logic [WORD_IDX_W-1:0] ret_cnt_s;
    logic                  last_beat_s;

    // Tie-break between simultaneous requests
    always_comb begin
        pick_i_s = 1'b0;
        pick_d_s = 1'b0;
        if (bus.i_req && bus.d_req) begin
`ifdef ARB_FIXED_PRIO_EN
            pick_d_s = 1'b1;
`else
            pick_d_s = (last_gnt_r == GNT_I);
            pick_i_s = (last_gnt_r == GNT_D);
`endif
        end else begin
            pick_i_s = bus.i_req;
            pick_d_s = bus.d_req;
        end
    end

    assign fill_s       = (state_r == I_FILL) || (state_r == D_FILL);
    assign beat_s       = fill_s && bus.mem_rdata_valid;
    assign start_s      = (state_r == IDLE) && (pick_i_s || (pick_d_s && !bus.d_we));
    assign issue_step_s = fill_s && issue_active_s;

    arb_burst_counter u_burst_counter (
        .clk          (clk),
        .rst          (rst),
        .start        (start_s),
        .issue_step   (issue_step_s),
        .beat         (beat_s),
        .issue_idx    (issue_idx_s),
        .issue_active (issue_active_s),
        .ret_cnt      (ret_cnt_s),
        .last_beat    (last_beat_s)
    );

    // Arbiter FSM; memory command and grants are registered one cycle ahead of use
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_gnt_r   <= GNT_I;
            blk_r        <= 12'h000;
            mem_addr_r   <= 16'h0000;
            mem_enable_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_wdata_r  <= 16'h0000;
            i_grant_r    <= 1'b0;
            d_grant_r    <= 1'b0;
        end else begin
            mem_addr_r   <= 16'h0000;
            mem_enable_r <= 1'b0;
            mem_wr_r     <= 1'b0;
            mem_wdata_r  <= 16'h0000;
            case (state_r)
                IDLE: begin
                    if (pick_d_s) begin
                        last_gnt_r   <= GNT_D;
                        d_grant_r    <= 1'b1;
                        mem_enable_r <= 1'b1;
                        if (bus.d_we) begin
                            state_r     <= D_WRITE;
                            mem_wr_r    <= 1'b1;
                            mem_addr_r  <= bus.d_addr;
                            mem_wdata_r <= bus.d_wdata;
                        end else begin
                            state_r    <= D_FILL;
                            blk_r      <= bus.d_addr[15:4];
                            mem_addr_r <= word_addr(bus.d_addr[15:4], WORD_IDX_W'(0));
                        end
                    end else if (pick_i_s) begin
                        state_r      <= I_FILL;
                        last_gnt_r   <= GNT_I;
                        i_grant_r    <= 1'b1;
                        blk_r        <= bus.i_addr[15:4];
                        mem_enable_r <= 1'b1;
                        mem_addr_r   <= word_addr(bus.i_addr[15:4], WORD_IDX_W'(0));
                    end else begin
                        state_r <= IDLE;
                    end
                end
                I_FILL, D_FILL: begin
                    if (issue_active_s) begin
                        mem_enable_r <= 1'b1;
                        mem_addr_r   <= word_addr(blk_r, issue_idx_s);
                    end
                    if (last_beat_s) begin
                        state_r   <= IDLE;
                        i_grant_r <= 1'b0;
                        d_grant_r <= 1'b0;
                    end
                end
                D_WRITE: begin
                    state_r   <= IDLE;
                    d_grant_r <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    i_grant_r <= 1'b0;
                    d_grant_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_enable = mem_enable_r;
    assign bus.mem_wr     = mem_wr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.i_grant    = i_grant_r;
    assign bus.d_grant    = d_grant_r;

    // Read returns reach the owner in the cycle they arrive; zero when not a fill beat
    assign bus.fill_data    = beat_s ? bus.mem_rdata : 16'h0000;
    assign bus.fill_word    = beat_s ? ret_cnt_s : 3'd0;
    assign bus.i_data_valid = beat_s && (state_r == I_FILL);
    assign bus.d_data_valid = beat_s && (state_r == D_FILL);
    assign bus.i_done       = last_beat_s && (state_r == I_FILL);
    assign bus.d_done       = (last_beat_s && (state_r == D_FILL)) || (state_r == D_WRITE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed requests push expected bus cycles,
// a negedge monitor compares every cycle (idle cycles must be all-zero).
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    typedef struct packed {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        idv;
        logic        ddv;
        logic [2:0]  word;
        logic [15:0] data;
        logic        idone;
        logic        ddone;
        logic        igr;
        logic        dgr;
    } rec_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_vec = 0;
    int    n_fail = 0;
    int    cyc = 0;
    bit    mon_en = 1'b0;
    rec_t  exp_q[$];
    ret_t  ret_q[$];

    cache_mem_arbiter_if bus();

    cache_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("en=%b wr=%b addr=%h wd=%h idv=%b ddv=%b w=%0d d=%h idn=%b ddn=%b ig=%b dg=%b",
                         r.en, r.wr, r.addr, r.wdata, r.idv, r.ddv, r.word, r.data,
                         r.idone, r.ddone, r.igr, r.dgr);
    endfunction

    // Expected bus cycles of a fill burst, first n cycles of the state
    function automatic void push_fill(input bit is_d, input logic [15:0] a, input int n);
        rec_t        r;
        logic [15:0] base;
        base = {a[15:4], 4'h0};
        for (int k = 1; k <= n; k++) begin
            r     = '0;
            r.igr = !is_d;
            r.dgr = is_d;
            if (k <= BLOCK_WORDS) begin
                r.en   = 1'b1;
                r.addr = base + 16'((k - 1) * 2);
            end
            if (k > MEM_LATENCY) begin
                r.word = 3'(k - MEM_LATENCY - 1);
                r.data = mem_word(base + 16'((k - MEM_LATENCY - 1) * 2));
                r.idv  = !is_d;
                r.ddv  = is_d;
            end
            if (k == BLOCK_WORDS + MEM_LATENCY) begin
                r.idone = !is_d;
                r.ddone = is_d;
            end
            exp_q.push_back(r);
        end
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait at negedge for one DUT output; an expired budget is a failure
    task automatic wait_for(input int sel, input int budget, input string what);
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < budget && !hit; t++) begin
            @(negedge clk);
            case (sel)
                0:       hit = (bus.i_done === 1'b1);
                1:       hit = (bus.d_done === 1'b1);
                2:       hit = (bus.mem_enable === 1'b1);
                default: hit = 1'b0;
            endcase
        end
        n_vec++;
        if (!hit) begin
            n_fail++;
            $display("FAIL timeout_%s: no event within %0d cycles", what, budget);
        end
    endtask

    // Memory model: fixed-latency read returns, one cycle per beat
    initial begin
        bus.mem_rdata       = 16'h0000;
        bus.mem_rdata_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                bus.mem_rdata_valid = 1'b1;
                bus.mem_rdata       = ret_q[0].data;
                void'(ret_q.pop_front());
            end else begin
                bus.mem_rdata_valid = 1'b0;
                bus.mem_rdata       = 16'hDEAD;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0)
            ret_q.push_back('{due: cyc + MEM_LATENCY, data: mem_word(bus.mem_addr)});
    end

    // Monitor: active cycles pop the scoreboard, idle cycles must show all outputs zero
    always @(negedge clk) begin
        rec_t obs;
        rec_t e;
        if (mon_en) begin
            obs.en    = bus.mem_enable;
            obs.wr    = bus.mem_wr;
            obs.addr  = bus.mem_addr;
            obs.wdata = bus.mem_wdata;
            obs.idv   = bus.i_data_valid;
            obs.ddv   = bus.d_data_valid;
            obs.word  = bus.fill_word;
            obs.data  = bus.fill_data;
            obs.idone = bus.i_done;
            obs.ddone = bus.d_done;
            obs.igr   = bus.i_grant;
            obs.dgr   = bus.d_grant;
            e = '0;
            if ((obs.en | obs.idv | obs.ddv | obs.idone | obs.ddone) === 1'b1) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
            end
            n_vec++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL bus_cycle cyc=%0d got {%s} expected {%s}", cyc, fmt(obs), fmt(e));
            end
        end
    end

    initial begin
        rec_t wr_rec;
        int   t0;
        int   t1;
        int   beats;

        bus.i_req   = 1'b0;
        bus.i_addr  = 16'h0000;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0000;
        bus.d_wdata = 16'h0000;

        // Reset: outputs checked as zero while reset is still held
        rst = 1'b1;
        step(2);
        mon_en = 1'b1;
        step(1);
        rst = 1'b0;
        step(2);

        // Stray read return in IDLE must not reach either cache
        @(negedge clk);
        ret_q.push_back('{due: cyc + 2, data: 16'h1111});
        step(4);

        // Simultaneous fills after reset: D first (last grant was I), then I
        push_fill(1'b1, 16'h0B20, 12);
        push_fill(1'b0, 16'h0A10, 12);
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0A10;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0B20;
        wait_for(1, 30, "tie_d_done");
        step(1);
        bus.d_req = 1'b0;
        wait_for(0, 30, "tie_i_done");
        step(1);
        bus.i_req = 1'b0;
        step(2);

        // I-fill alone at 0x1234, with done-latency check
        push_fill(1'b0, 16'h1234, 12);
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h1234;
        wait_for(2, 10, "ifill_issue");
        t0 = cyc;
        wait_for(0, 30, "ifill_done");
        t1 = cyc;
        n_vec++;
        if (t1 - t0 != BLOCK_WORDS + MEM_LATENCY - 1) begin
            n_fail++;
            $display("FAIL ifill_latency: got %0d cycles, expected %0d", t1 - t0,
                     BLOCK_WORDS + MEM_LATENCY - 1);
        end
        step(1);
        bus.i_req = 1'b0;
        step(2);

        // D write-through: single cycle command with done
        wr_rec       = '0;
        wr_rec.en    = 1'b1;
        wr_rec.wr    = 1'b1;
        wr_rec.addr  = 16'h0040;
        wr_rec.wdata = 16'hBEEF;
        wr_rec.ddone = 1'b1;
        wr_rec.dgr   = 1'b1;
        exp_q.push_back(wr_rec);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0040;
        bus.d_wdata = 16'hBEEF;
        wait_for(1, 6, "dwrite_done");
        step(1);
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_wdata = 16'h0000;
        step(2);

        // Back-to-back: D arrives mid I-burst and I stays asserted; D goes next, then I.
        // The I address change mid-burst only applies to the later I burst.
        push_fill(1'b0, 16'h2000, 12);
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h2000;
        wait_for(2, 10, "b2b_issue");
        step(3);
        push_fill(1'b1, 16'h3456, 12);
        push_fill(1'b0, 16'h2050, 12);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h3456;
        bus.i_addr = 16'h2050;
        wait_for(0, 30, "b2b_i_done");
        wait_for(1, 30, "b2b_d_done");
        step(1);
        bus.d_req = 1'b0;
        wait_for(0, 30, "b2b_i2_done");
        step(1);
        bus.i_req = 1'b0;
        step(2);

        // D fill whose request and address drop mid-burst still completes
        push_fill(1'b1, 16'hABCD, 12);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'hABCD;
        wait_for(2, 10, "dfill_issue");
        step(2);
        bus.d_req  = 1'b0;
        bus.d_addr = 16'hFFFF;
        wait_for(1, 30, "dfill_done");
        step(3);

        // Reset on the 5th beat: no done, the remaining returns are ignored
        push_fill(1'b0, 16'h7770, 9);
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h7770;
        beats = 0;
        for (int t = 0; t < 40 && beats < 5; t++) begin
            @(negedge clk);
            if (bus.i_data_valid === 1'b1) beats++;
        end
        n_vec++;
        if (beats != 5) begin
            n_fail++;
            $display("FAIL rst_beats: got %0d beats, expected 5", beats);
        end
        rst       = 1'b1;
        bus.i_req = 1'b0;
        step(1);
        rst = 1'b0;
        step(10);

        // Drain: every expected bus cycle must have been seen
        for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected cycles left, expected 0", exp_q.size());
        end
        step(2);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port i_req, input, 1, I-cache fill request; held high until i_done.
REQ-004 SHALL have port i_addr, input, 16, I-cache missed address; bits [15:4] select the block.
REQ-005 SHALL have port d_req, input, 1, D-cache request (fill or write); held high until d_done.
REQ-006 SHALL have ports d_we, input, 1, and d_addr, input, 16: D request type (1 = write-through word) and address.
REQ-007 SHALL have port d_wdata, input, 16, D-cache write data.
REQ-008 SHALL have ports mem_addr, output, 16; mem_enable, output, 1; mem_wr, output, 1; mem_wdata, output, 16: shared memory command.
REQ-009 SHALL have ports mem_rdata, input, 16, and mem_rdata_valid, input, 1: memory read return, fixed 4-cycle latency.
REQ-010 SHALL have ports i_grant and d_grant, outputs, 1: current owner of memory.
REQ-011 SHALL have ports fill_data, output, 16; fill_word, output, 3; i_data_valid and d_data_valid, outputs, 1: routed fill beat.
REQ-012 SHALL have ports i_done and d_done, outputs, 1: one-cycle completion pulses.

Function
REQ-013 SHALL implement states IDLE, I_FILL, D_FILL, D_WRITE.
REQ-014 IDLE: sample requests; the selected requester enters its state next cycle; if neither requests, remain in IDLE.
REQ-015 d_req with d_we=1 SHALL enter D_WRITE; d_req with d_we=0 SHALL enter D_FILL.
REQ-016 Both requesting in IDLE: winner per REQ-029/030.
REQ-017 Grant SHALL be high for the whole time in the owner's state and low in IDLE.
REQ-018 Fill states: issue counter 0..7; each cycle mem_enable=1, mem_wr=0, mem_addr={block[15:4], cnt, 1'b0}; 8 consecutive issue cycles, starting in the first cycle of the state.
REQ-019 Return counter 0..7: each mem_rdata_valid during a fill SHALL drive fill_data=mem_rdata and fill_word=return count, and assert the owner's *_data_valid in the same cycle (combinational pass-through).
REQ-020 On the 8th valid beat the owner's done SHALL pulse in that same cycle; IDLE SHALL follow on the next cycle.
REQ-021 Burst latency: the first beat arrives 4 cycles after the first issue; done occurs 11 cycles after the first issue cycle (12th cycle of the state).
REQ-022 D_WRITE: one cycle, mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1; IDLE next.
REQ-023 Block address SHALL be latched on entry to the state; changes to the request address mid-burst are ignored.
REQ-024 Requests deasserted mid-burst SHALL NOT abort the burst.
REQ-025 mem_rdata_valid in IDLE or D_WRITE SHALL be ignored (no data_valid, no counter change).
REQ-026 Outside issue cycles and D_WRITE, mem_enable, mem_wr, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-027 rst SHALL force IDLE, zero both counters, and clear last-grant to I; all outputs 0 in the cycle following reset.
REQ-028 Reset mid-burst SHALL abort the burst without a done pulse; memory returns still in flight arrive in IDLE and are ignored.

Configuration
REQ-029 With ARB_FIXED_PRIO_EN defined: D always wins a simultaneous request.
REQ-030 Without ARB_FIXED_PRIO_EN: round-robin; on a tie the requester not granted last wins; last-grant updates on each grant.

Structure
REQ-031 A shared package cache_pkg SHALL hold the state encoding, BLOCK_WORDS=8 and MEM_LATENCY=4.
REQ-032 Sub-module arb_burst_counter (issue and return counters, done detect) SHALL be the only child instance.

Verification
REQ-033 I-fill alone: i_req=1, i_addr=0x1234 -> mem_addr 0x1230, 0x1232, ..., 0x123E on 8 consecutive cycles; fill_word 0..7; i_done 11 cycles after the first issue.
REQ-034 D write: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0xBEEF -> one cycle with mem_wr=1 and d_done=1; IDLE next cycle.
REQ-035 Simultaneous i_req and d_req fill after reset -> round-robin build: I served first (last-grant=I after reset means D wins? no: I not granted last is D) -- D served first, then I; fixed-priority build: D first.
REQ-036 Back-to-back: i_req held after i_done while d_req pending -> round-robin grants D next.
REQ-037 rst pulsed on the 5th fill beat -> no done pulse; the 3 remaining valids are ignored; all outputs 0.
REQ-038 Stray mem_rdata_valid in IDLE -> i_data_valid and d_data_valid stay 0.
